// File: rtl/height_history_renderer.sv
// Height history renderer: keeps the last DEPTH height samples and draws each one as an F'II" glyph row.
// Optional feature macro NEWEST_BLINK_EN: the newest entry blinks with a 64-frame period.
module height_history_renderer #(
    parameter int unsigned DEPTH        = 10,
    parameter int unsigned START_X      = 50,
    parameter int unsigned START_Y      = 50,
    parameter int unsigned ROW_HEIGHT   = 40,
    parameter int unsigned CHAR_SPACING = 2,
    parameter int unsigned SCALE_SHIFT  = 1,
    parameter logic [5:0]  BG_COLOR     = 6'h3F
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sample_valid,
    input  logic [7:0] sample_inches,
    input  logic       clear,
    input  logic       frame_start,
    input  logic [9:0] Row,
    input  logic [9:0] Col,
    input  logic       valid,
    output logic [5:0] rgb_out,
    output logic [4:0] entry_count,
    output logic       sample_clamped
);

    localparam int unsigned GLYPH_W     = 8 << SCALE_SHIFT;
    localparam int unsigned GLYPH_H     = 16 << SCALE_SHIFT;
    localparam int unsigned SLOT_PITCH  = GLYPH_W + CHAR_SPACING;
    localparam logic [7:0]  MAX_INCHES  = 8'd107;
    localparam logic [5:0]  INK_COLOR   = 6'h30;
    localparam logic [3:0]  GLYPH_APOS  = 4'd10;
    localparam logic [3:0]  GLYPH_QUOTE = 4'd11;

    // 8x16 font, row 0 in the top byte, leftmost pixel in bit 7 of each byte.
    function automatic logic [7:0] glyph_row(input logic [3:0] g, input logic [3:0] r);
        logic [127:0] bm;
        logic [6:0]   base;
        case (g)
            4'd0:    bm = 128'h00003C66666E76666666663C00000000;
            4'd1:    bm = 128'h00001838781818181818187E00000000;
            4'd2:    bm = 128'h00003C6606060C183060667E00000000;
            4'd3:    bm = 128'h00003C6606061C060606663C00000000;
            4'd4:    bm = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            4'd5:    bm = 128'h00007E6060607C060606663C00000000;
            4'd6:    bm = 128'h00001C3060607C666666663C00000000;
            4'd7:    bm = 128'h00007E66060C18303030303000000000;
            4'd8:    bm = 128'h00003C6666663C666666663C00000000;
            4'd9:    bm = 128'h00003C6666663E06060C187000000000;
            4'd10:   bm = 128'h00001818183000000000000000000000;
            4'd11:   bm = 128'h00006666664400000000000000000000;
            default: bm = '0;
        endcase
        base = {4'd15 - r, 3'b000};
        return bm[base +: 8];
    endfunction

    logic [6:0] hist_q [DEPTH];
    logic [6:0] hist_d [DEPTH];
    logic [6:0] snap_q [DEPTH];
    logic [6:0] snap_d [DEPTH];
    logic [3:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] count_q, count_d;
    logic [3:0] snap_ptr_q, snap_ptr_d;
    logic [4:0] snap_cnt_q, snap_cnt_d;
    logic       clamped_q, clamped_d;
    logic [6:0] sample_sat;

    always_comb begin
        sample_sat = (sample_inches > MAX_INCHES) ? MAX_INCHES[6:0] : sample_inches[6:0];
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        hist_d     = hist_q;
        clamped_d  = 1'b0;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (sample_valid) begin
            hist_d[wr_ptr_q] = sample_sat;
            wr_ptr_d  = (wr_ptr_q == 4'(DEPTH - 1)) ? '0 : wr_ptr_q + 4'd1;
            count_d   = (count_q == 5'(DEPTH)) ? count_q : count_q + 5'd1;
            clamped_d = sample_inches > MAX_INCHES;
        end
    end

    // Snapshot samples the pre-write history, so a coincident sample shows up next frame.
    always_comb begin
        snap_d     = snap_q;
        snap_ptr_d = snap_ptr_q;
        snap_cnt_d = snap_cnt_q;
        if (frame_start) begin
            snap_d     = hist_q;
            snap_ptr_d = wr_ptr_q;
            snap_cnt_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
                snap_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            count_q    <= '0;
            snap_ptr_q <= '0;
            snap_cnt_q <= '0;
            clamped_q  <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            snap_q     <= snap_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            snap_ptr_q <= snap_ptr_d;
            snap_cnt_q <= snap_cnt_d;
            clamped_q  <= clamped_d;
        end
    end

`ifdef NEWEST_BLINK_EN
    logic [5:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_start ? frame_cnt_q + 6'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_cnt_q <= '0;
        else          frame_cnt_q <= frame_cnt_d;
    end
`endif

    logic [10:0] row_w, col_w, yoff, xoff;
    logic        hit_y, hit_x;
    logic [3:0]  k_sel;
    logic [2:0]  slot_sel;
    logic [5:0]  ent_sum;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_hit_q, s1_hit_d;
    logic [3:0]  s1_k_q, s1_k_d;
    logic [2:0]  s1_slot_q, s1_slot_d;
    logic [2:0]  s1_xoff_q, s1_xoff_d;
    logic [3:0]  s1_yoff_q, s1_yoff_d;
    logic [6:0]  s1_val_q, s1_val_d;

    always_comb begin
        row_w    = {1'b0, Row};
        col_w    = {1'b0, Col};
        hit_y    = 1'b0;
        hit_x    = 1'b0;
        k_sel    = '0;
        slot_sel = '0;
        yoff     = '0;
        xoff     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (row_w >= 11'(START_Y + k * ROW_HEIGHT) &&
                row_w <  11'(START_Y + k * ROW_HEIGHT + GLYPH_H)) begin
                hit_y = 1'b1;
                k_sel = 4'(k);
                yoff  = row_w - 11'(START_Y + k * ROW_HEIGHT);
            end
        end
        for (int unsigned j = 0; j < 5; j++) begin
            if (col_w >= 11'(START_X + j * SLOT_PITCH) &&
                col_w <  11'(START_X + j * SLOT_PITCH + GLYPH_W)) begin
                hit_x    = 1'b1;
                slot_sel = 3'(j);
                xoff     = col_w - 11'(START_X + j * SLOT_PITCH);
            end
        end
        // Newest entry sits just behind the snapshot write pointer.
        ent_sum = 6'(DEPTH - 1) + {2'b00, snap_ptr_q} - {2'b00, k_sel};
        if (ent_sum >= 6'(DEPTH)) ent_sum = ent_sum - 6'(DEPTH);

        s1_valid_d = valid;
        s1_hit_d   = hit_y && hit_x;
        s1_k_d     = k_sel;
        s1_slot_d  = slot_sel;
        s1_xoff_d  = 3'(xoff >> SCALE_SHIFT);
        s1_yoff_d  = 4'(yoff >> SCALE_SHIFT);
        s1_val_d   = snap_q[ent_sum[3:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_k_q     <= '0;
            s1_slot_q  <= '0;
            s1_xoff_q  <= '0;
            s1_yoff_q  <= '0;
            s1_val_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_hit_q   <= s1_hit_d;
            s1_k_q     <= s1_k_d;
            s1_slot_q  <= s1_slot_d;
            s1_xoff_q  <= s1_xoff_d;
            s1_yoff_q  <= s1_yoff_d;
            s1_val_q   <= s1_val_d;
        end
    end

    logic [3:0] feet, inches, tens, ones, glyph;
    logic [7:0] font_bits;
    logic       ink, blink_hide;
    logic [5:0] rgb_q, rgb_d;

    always_comb begin
        feet   = 4'(s1_val_q / 7'd12);
        inches = 4'(s1_val_q % 7'd12);
        tens   = (inches >= 4'd10) ? 4'd1 : 4'd0;
        ones   = (inches >= 4'd10) ? inches - 4'd10 : inches;
        case (s1_slot_q)
            3'd0:    glyph = feet;
            3'd1:    glyph = GLYPH_APOS;
            3'd2:    glyph = tens;
            3'd3:    glyph = ones;
            default: glyph = GLYPH_QUOTE;
        endcase
        font_bits = glyph_row(glyph, s1_yoff_q);
        ink       = font_bits[3'd7 - s1_xoff_q];
`ifdef NEWEST_BLINK_EN
        blink_hide = frame_cnt_q[5] && (s1_k_q == 4'd0);
`else
        blink_hide = 1'b0;
`endif
        rgb_d = '0;
        if (s1_valid_q) begin
            rgb_d = BG_COLOR;
            if (s1_hit_q && ({1'b0, s1_k_q} < snap_cnt_q) && !blink_hide && ink)
                rgb_d = INK_COLOR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rgb_q <= '0;
        else          rgb_q <= rgb_d;
    end

    assign rgb_out        = rgb_q;
    assign entry_count    = count_q;
    assign sample_clamped = clamped_q;

endmodule
